lsu_ctrl: RTL and testbench

Load/store sequencer for the RV32I core. It sits between the decode stage outputs (mem_read, mem_write, funct3, ALU address, rs2 operand) and an external data-memory port with a req/gnt/rvalid handshake. It stalls the core while an access is outstanding and generates byte enables and store-lane replication. It returns aligned, sign- or zero-extended load data to the register-file write path.

---
 rtl/rv32i_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 26 ++
 rtl/lsu_ctrl.sv | 155 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, byte-enable patterns,
// sequencer states and the access-size decode used by the LSU.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    // Any funct3 that is not a legal encoding for the access kind is a word access.
    function automatic lsu_size_e access_size(input logic [2:0] f3, input logic is_load);
        if (is_load) begin
            case (f3)
                F3_LB, F3_LBU: return SZ_BYTE;
                F3_LH, F3_LHU: return SZ_HALF;
                F3_LW:         return SZ_WORD;
                default:       return SZ_WORD;
            endcase
        end
        case (f3)
            F3_SB:   return SZ_BYTE;
            F3_SH:   return SZ_HALF;
            F3_SW:   return SZ_WORD;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load-data alignment: selects the addressed byte/halfword lane of a memory
// word and sign- or zero-extends it according to funct3.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_word
);

    logic [15:0] lane;

    always_comb begin
        lane = 16'(rdata >> {offset, 3'b000});
        case (funct3)
            F3_LB:   load_word = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_word = {{16{lane[15]}}, lane};
            F3_LBU:  load_word = {24'h0, lane[7:0]};
            F3_LHU:  load_word = {16'h0, lane};
            F3_LW:   load_word = rdata;
            default: load_word = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: stalls the core while a data-memory access is in
// flight over the req/gnt/rvalid port and returns aligned load data.
module lsu_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout,
    output logic        req,
    output logic        we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state, state_n;
    lsu_size_e   size;
    logic [15:0] wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        aborted;
    logic        start, mis_cond, expired, accept, capture;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] align_word;

    assign start   = mem_read | mem_write;
    assign size    = access_size(funct3, mem_read);
    assign expired = (wait_cnt == 16'(MAX_WAIT));

    always_comb begin
        mis_cond = 1'b0;
        be_n     = BE_WORD;
        wdata_n  = store_data;
        case (size)
            SZ_BYTE: begin
                be_n    = BE_BYTE << addr[1:0];
                wdata_n = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                mis_cond = addr[0];
                be_n     = BE_HALF << addr[1:0];
                wdata_n  = {2{store_data[15:0]}};
            end
            default: mis_cond = (addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        state_n    = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        load_valid = 1'b0;
        timeout    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mis_cond) begin
                        misaligned = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        accept  = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (expired) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end else if (gnt) begin
                    state_n = we ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                stall = 1'b1;
                if (expired) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end else if (mem_rvalid) begin
                    capture = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                load_valid = ~we & ~aborted;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req       <= 1'b0;
            we        <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            load_data <= '0;
            wait_cnt  <= '0;
            aborted   <= 1'b0;
        end else begin
            state <= state_n;
            // req is registered but tracks the next state so it drops on gnt/timeout
            req   <= (state_n == REQ);
            if (accept) begin
                we        <= ~mem_read;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= be_n;
                mem_wdata <= wdata_n;
                f3_q      <= funct3;
                off_q     <= addr[1:0];
                wait_cnt  <= '0;
                aborted   <= 1'b0;
            end else if (state == REQ || state == WAIT_R) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (timeout) begin
                aborted <= 1'b1;
            end
            if (capture) begin
                load_data <= align_word;
            end
        end
    end

    lsu_align u_align (
        .funct3    (f3_q),
        .offset    (off_q),
        .rdata     (mem_rdata),
        .load_word (align_word)
    );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and randomized loads/stores against a
// behavioural size/lane/extension model, plus timeout and async-reset cases.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic        gnt = 1'b0, mem_rvalid = 1'b0, gnt_never = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        stall, load_valid, misaligned, timeout, req, we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        t_stall, t_load_valid, t_misaligned, t_timeout, t_req, t_we;
    logic [31:0] t_load_data, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_ld = '0;

    always #5 clk = ~clk;

    lsu_ctrl #(.MAX_WAIT(255)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .load_valid(load_valid), .load_data(load_data),
        .misaligned(misaligned), .timeout(timeout), .req(req), .we(we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .gnt(gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.MAX_WAIT(4)) dut_to (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(t_stall), .load_valid(t_load_valid), .load_data(t_load_data),
        .misaligned(t_misaligned), .timeout(t_timeout), .req(t_req), .we(t_we),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_be(t_mem_be),
        .gnt(gnt_never), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_size(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned s;
        logic [31:0] v, mask;
        s = ref_size(1'b1, f3);
        if (s == 4) return rd;
        v    = rd >> (8 * a[1:0]);
        mask = (32'd1 << (8 * s)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit ld, input bit both, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input int unsigned gw, input int unsigned rw, input logic [31:0] rd);
        int unsigned s;
        bit          mis;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        s   = ref_size(ld, f3);
        mis = (32'(a[1:0]) % s) != 0;
        ebe = 4'(((32'd1 << s) - 32'd1) << a[1:0]);
        ewd = (s == 1) ? 32'(d[7:0]) * 32'h01010101 :
              (s == 2) ? 32'(d[15:0]) * 32'h00010001 : d;

        mem_read = ld; mem_write = !ld | both;
        funct3 = f3; addr = a; store_data = d;
        @(negedge clk);
        chk1("misaligned", misaligned, mis);
        chk1("stall_issue", stall, !mis);
        chk1("req_issue", req, 1'b0);
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
        if (mis) begin
            @(negedge clk);
            chk1("mis_no_req", req, 1'b0);
            chk1("mis_no_stall", stall, 1'b0);
            tick();
            return;
        end
        for (int unsigned i = 0; i <= gw; i++) begin
            gnt = (i == gw);
            // an rvalid coinciding with gnt must be ignored
            mem_rvalid = (i == gw) ? 1'($urandom) : 1'b0;
            mem_rdata = $urandom;
            @(negedge clk);
            chk1("req", req, 1'b1);
            chk1("stall_req", stall, 1'b1);
            if (i == 0) begin
                chk1("we", we, !ld);
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_be", {28'h0, mem_be}, {28'h0, ebe});
                if (!ld) chk("mem_wdata", mem_wdata, ewd);
            end
            tick();
        end
        gnt = 1'b0; mem_rvalid = 1'b0;
        if (ld) begin
            for (int unsigned i = 0; i <= rw; i++) begin
                mem_rvalid = (i == rw);
                mem_rdata  = (i == rw) ? rd : $urandom;
                @(negedge clk);
                chk1("req_wait", req, 1'b0);
                chk1("stall_wait", stall, 1'b1);
                chk1("lv_wait", load_valid, 1'b0);
                tick();
            end
            mem_rvalid = 1'b0;
        end
        @(negedge clk);
        chk1("stall_done", stall, 1'b0);
        chk1("load_valid", load_valid, ld);
        if (ld) begin
            eld = ref_load(f3, a, rd);
            chk("load_data", load_data, eld);
            last_ld = eld;
        end else begin
            chk("load_data_hold", load_data, last_ld);
        end
        tick();
        @(negedge clk);
        chk1("lv_pulse_end", load_valid, 1'b0);
        tick();
    endtask

    initial begin
        #12;
        chk1("rst_req", req, 1'b0);
        chk1("rst_we", we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk1("rst_load_valid", load_valid, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        access(1'b0, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        access(1'b0, 1'b0, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);
        access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 2, 2, 32'h00800000);
        access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 2, 2, 32'h00800000);
        access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
        access(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0);
        access(1'b1, 1'b1, 3'b101, 32'h206, 32'h0, 1, 0, 32'hBEEF8001);

        for (int n = 0; n < 80; n++) begin
            bit ld;
            ld = 1'($urandom);
            access(ld, ld & 1'($urandom), 3'($urandom), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // timeout on the MAX_WAIT=4 instance, whose gnt is never asserted
        rst = 1'b0;
        tick();
        rst = 1'b1; last_ld = '0;
        tick();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        chk1("to_stall_issue", t_stall, 1'b1);
        tick();
        mem_read = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            chk1("to_req", t_req, 1'b1);
            chk1("to_pulse", t_timeout, i == 4);
            tick();
        end
        @(negedge clk);
        chk1("to_done_timeout", t_timeout, 1'b0);
        chk1("to_done_req", t_req, 1'b0);
        chk1("to_done_stall", t_stall, 1'b0);
        chk1("to_done_lv", t_load_valid, 1'b0);

        // main instance is still in REQ: reset must drop req without a clock edge
        chk1("pre_rst_req", req, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk1("async_rst_req", req, 1'b0);
        chk1("async_rst_stall", stall, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
        tick();
        mem_read = 1'b0; gnt = 1'b1;
        tick();
        gnt = 1'b0;
        @(negedge clk);
        chk1("wait_r_stall", stall, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk1("rst_wait_req", req, 1'b0);
        chk1("rst_wait_stall", stall, 1'b0);
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("late_rvalid_lv", load_valid, 1'b0);
            chk1("late_rvalid_stall", stall, 1'b0);
            tick();
        end
        mem_rvalid = 1'b0;
        chk("post_rst_load_data", load_data, 32'h0);
        access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 1, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
